// File: rtl/demux_nch_pkg.sv
// demux_nch_pkg: shared constants for the N-channel demux.
package demux_nch_pkg;
    localparam int MODE_SEL  = 0;
    localparam int MODE_RR   = 1;
    localparam int DEF_WIDTH = 10;
    localparam int DEF_N_CH  = 4;
    localparam int CNT_W     = 16;
endpackage

// File: rtl/demux_nch_rr_if.sv
// demux_nch_rr_if: input handshake plus per-channel output bus of the demux.
// word_cnt exists only when DEMUX_NCH_CNT_EN is defined.
interface demux_nch_rr_if
    import demux_nch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = $clog2(N_CH)
);
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_ready;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [N_CH-1:0]       out_ready;
    logic                  sel_err;
`ifdef DEMUX_NCH_CNT_EN
    logic [N_CH*CNT_W-1:0] word_cnt;
`endif
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, sel_err
`ifdef DEMUX_NCH_CNT_EN
        , output word_cnt
`endif
    );
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, sel_err
`ifdef DEMUX_NCH_CNT_EN
        , input word_cnt
`endif
    );
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry output holding register; a load in the drain cycle keeps it full.
module demux_slot #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_drain,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dout
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_load | (r_valid & ~i_drain);
            if (i_load) r_data <= i_din;
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = r_data;
endmodule

// File: rtl/demux_nch_rr.sv
// demux_nch_rr: N-channel demux, external select or round-robin, registered per-channel slots.
// Define DEMUX_NCH_CNT_EN to add per-channel accepted-word counters on word_cnt.
module demux_nch_rr
    import demux_nch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = $clog2(N_CH),
    parameter int MODE  = MODE_SEL
) (
    input logic           clk,
    input logic           reset,
    demux_nch_rr_if.slave bus
);
    logic [SEL_W-1:0]      r_rr_ptr;
    logic                  r_sel_err;
    logic [SEL_W-1:0]      w_tgt;
    logic                  w_in_range;
    logic                  w_acc;
    logic [N_CH-1:0]       w_hit;
    logic [N_CH-1:0]       w_load;
    logic [N_CH-1:0]       w_drain;
    logic [N_CH-1:0]       w_valid;
    logic [N_CH*WIDTH-1:0] w_data;

    assign w_tgt      = (MODE == MODE_RR) ? r_rr_ptr : bus.in_sel;
    assign w_in_range = {1'b0, w_tgt} < (SEL_W+1)'(N_CH);
    // Out-of-range targets are always ready so the word is swallowed
    assign bus.in_ready = ~w_in_range | (|(w_hit & (~w_valid | bus.out_ready)));
    assign w_acc   = bus.in_valid & bus.in_ready;
    assign w_load  = w_hit & {N_CH{w_acc}};
    assign w_drain = w_valid & bus.out_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        assign w_hit[i] = w_tgt == SEL_W'(i);
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[i]),
            .i_din   (bus.in_data),
            .i_drain (w_drain[i]),
            .o_valid (w_valid[i]),
            .o_dout  (w_data[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_acc & ~w_in_range;
            if (MODE == MODE_RR && w_acc)
                r_rr_ptr <= (r_rr_ptr == SEL_W'(N_CH-1)) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.sel_err   = r_sel_err;

`ifdef DEMUX_NCH_CNT_EN
    logic [CNT_W-1:0] r_cnt [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_cnt[i] <= '0;
            else if (w_load[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        assign bus.word_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
`endif
endmodule

// File: tb/tb_demux_nch_rr.sv
// tb_demux_nch_rr: directed scoreboard bench; A = 4ch select, B = 4ch round-robin, C = 3ch select.
module tb_demux_nch_rr;
    import demux_nch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux_nch_rr_if #(.WIDTH(10), .N_CH(4)) a ();
    demux_nch_rr_if #(.WIDTH(10), .N_CH(4)) b ();
    demux_nch_rr_if #(.WIDTH(10), .N_CH(3)) c ();

    demux_nch_rr #(.WIDTH(10), .N_CH(4), .MODE(MODE_SEL)) dut_a (.clk(clk), .reset(reset), .bus(a));
    demux_nch_rr #(.WIDTH(10), .N_CH(4), .MODE(MODE_RR))  dut_b (.clk(clk), .reset(reset), .bus(b));
    demux_nch_rr #(.WIDTH(10), .N_CH(3), .MODE(MODE_SEL)) dut_c (.clk(clk), .reset(reset), .bus(c));

    typedef struct {
        int         d;
        int         ch;
        logic [9:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void push(int d, int ch, logic [9:0] data);
        sb.push_back('{d, ch, data});
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Per-channel in-order match: the first pending word for (dut, channel)
    function automatic void got(int d, int ch, logic [9:0] data);
        int idx = -1;
        foreach (sb[k]) if (idx < 0 && sb[k].d == d && sb[k].ch == ch) idx = k;
        n_vec++;
        if (idx < 0) begin
            n_err++;
            $display("FAIL drain dut%0d ch%0d: got %0h expected no word", d, ch, data);
        end else begin
            if (sb[idx].data !== data) begin
                n_err++;
                $display("FAIL drain dut%0d ch%0d: got %0h expected %0h", d, ch, data, sb[idx].data);
            end
            sb.delete(idx);
        end
    endfunction

    always @(negedge clk) if (!reset)
        for (int i = 0; i < 4; i++)
            if (a.out_valid[i] && a.out_ready[i]) got(0, i, a.out_data[i*10 +: 10]);
    always @(negedge clk) if (!reset)
        for (int j = 0; j < 4; j++)
            if (b.out_valid[j] && b.out_ready[j]) got(1, j, b.out_data[j*10 +: 10]);
    always @(negedge clk) if (!reset)
        for (int m = 0; m < 3; m++)
            if (c.out_valid[m] && c.out_ready[m]) got(2, m, c.out_data[m*10 +: 10]);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a.in_valid = 0; a.in_data = 0; a.in_sel = 0; a.out_ready = 4'hF;
        b.in_valid = 0; b.in_data = 0; b.in_sel = 0; b.out_ready = 4'hF;
        c.in_valid = 0; c.in_data = 0; c.in_sel = 0; c.out_ready = 3'h7;
        repeat (2) tick;
        neg;
        chk("rst_valid_a", a.out_valid, 0);
        chk("rst_data_a", a.out_data, 0);
        chk("rst_ready_a", a.in_ready, 1);
        chk("rst_selerr_a", a.sel_err, 0);
        chk("rst_valid_b", b.out_valid, 0);
        tick; reset = 1'b0;

        // 1: single word to slot 2, one-cycle latency then drained
        tick; a.in_valid = 1; a.in_data = 10'h155; a.in_sel = 2; push(0, 2, 10'h155);
        neg;  chk("t1_in_ready", a.in_ready, 1);
        tick; a.in_valid = 0;
        neg;  chk("t1_out_valid", a.out_valid, 4'b0100);
        tick; neg; chk("t1_empty", a.out_valid, 0);

        // 2: backpressure on slot 1, then drain and reload on the same edge
        tick; a.out_ready = 4'b1101; a.in_valid = 1; a.in_data = 10'h011; a.in_sel = 1; push(0, 1, 10'h011);
        neg;  chk("t2_first_ready", a.in_ready, 1);
        tick; a.in_data = 10'h022; push(0, 1, 10'h022);
        neg;  chk("t2_stall", a.in_ready, 0);
        chk("t2_held", a.out_valid, 4'b0010);
        tick; neg; chk("t2_stall2", a.in_ready, 0);
        tick; a.out_ready = 4'hF;
        neg;  chk("t2_passthru_ready", a.in_ready, 1);
        tick; a.in_valid = 0;
        neg;  chk("t2_still_valid", a.out_valid, 4'b0010);
        tick; neg; chk("t2_empty", a.out_valid, 0);

        // 3: round-robin order 0,1,2,3,0,1
        for (int k = 1; k <= 6; k++) begin
            tick; b.in_valid = 1; b.in_data = 10'(k); push(1, (k - 1) % 4, 10'(k));
            neg;  chk("t3_ready", b.in_ready, 1);
        end
        tick; b.in_valid = 0;

        // 4: pointer now 2; slot 2 blocked stalls only the pointer, others drain
        tick; b.out_ready = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            tick; b.in_valid = 1; b.in_data = 10'h0A0 + 10'(k); push(1, (2 + k) % 4, 10'h0A0 + 10'(k));
            neg;  chk("t4_ready", b.in_ready, 1);
        end
        tick; b.in_data = 10'h0A4; push(1, 2, 10'h0A4);
        neg;  chk("t4_stall", b.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick; neg; chk("t4_stall_hold", b.in_ready, 0);
        end
        chk("t4_others_drained", b.out_valid, 4'b0100);
        tick; b.out_ready = 4'hF;
        neg;  chk("t4_release", b.in_ready, 1);
        tick; b.in_data = 10'h0A5; push(1, 3, 10'h0A5);
        neg;  chk("t4_next_ready", b.in_ready, 1);
        tick; b.in_valid = 0;
        repeat (3) tick;

        // 5: out-of-range select on the 3-channel instance
        tick; c.in_valid = 1; c.in_sel = 3; c.in_data = 10'h3FF;
        neg;  chk("t5_ready", c.in_ready, 1);
        chk("t5_no_err_yet", c.sel_err, 0);
        tick; c.in_valid = 0;
        neg;  chk("t5_sel_err", c.sel_err, 1);
        chk("t5_no_slot", c.out_valid, 0);
`ifdef DEMUX_NCH_CNT_EN
        chk("t5_cnt_zero", c.word_cnt, 0);
`endif
        tick; neg; chk("t5_err_pulse", c.sel_err, 0);
        tick; c.in_valid = 1; c.in_sel = 2; c.in_data = 10'h123; push(2, 2, 10'h123);
        tick; c.in_valid = 0;
        neg;  chk("t5_valid_c", c.out_valid, 3'b100);
        chk("t5_no_err", c.sel_err, 0);
`ifdef DEMUX_NCH_CNT_EN
        chk("t5_cnt_one", c.word_cnt, 48'h0001_0000_0000);
`endif
        repeat (2) tick;
        neg; chk("sb_before_t6", sb.size(), 0);

        // 6: fill every slot, then reset between edges
        tick; a.out_ready = 4'h0; a.in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            a.in_sel = 2'(k); a.in_data = 10'h200 + 10'(k); push(0, k, 10'h200 + 10'(k));
            tick;
        end
        a.in_valid = 0;
        neg; chk("t6_full", a.out_valid, 4'hF);
        #2; reset = 1'b1; #1;
        chk("t6_rst_valid", a.out_valid, 0);
        chk("t6_rst_data", a.out_data, 0);
        chk("t6_rst_ready", a.in_ready, 1);
        sb.delete();
        tick; reset = 1'b0; a.out_ready = 4'hF;
        tick;
        a.in_valid = 1; a.in_sel = 0; a.in_data = 10'h0C5; push(0, 0, 10'h0C5);
        b.in_valid = 1; b.in_data = 10'h0B0; push(1, 0, 10'h0B0);
        neg;  chk("t6_ready_a", a.in_ready, 1);
        tick; a.in_valid = 0; b.in_valid = 0;
        neg;  chk("t6_latency_a", a.out_valid, 4'b0001);
        chk("t6_rr_restart_b", b.out_valid, 4'b0001);
        repeat (2) tick;
        neg; chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux_nch_rr.md
Name: demux_nch_rr

Overview:
- Parametrised N-channel demultiplexer with a registered output per channel and valid/ready handshakes on the input and on every output.
- Supersedes the fixed 4-channel, 10-bit demux that feeds the per-channel FIFOs in the round-robin datapath.
- Routes each accepted input word to one output slot. The slot is chosen by an external select (MODE=0) or by an internal round-robin pointer (MODE=1).
- Each output slot holds its word until the downstream FIFO accepts it, so downstream backpressure stalls only the input words targeting that slot.

Parameters:
- WIDTH, 10: data word width in bits.
- N_CH, 4: number of output channels; legal range 2..16.
- SEL_W, $clog2(N_CH): width of the select field.
- MODE, 0: 0 = external select via in_sel; 1 = internal round-robin pointer, in_sel ignored.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  target channel; used only when MODE=0.
- in_ready  out  1  block can accept the input word this cycle.
- out_valid  out  N_CH  bit i high means slot i holds a word.
- out_data  out  N_CH*WIDTH  slot i occupies bits [i*WIDTH +: WIDTH].
- out_ready  in  N_CH  downstream FIFO i can take a word (its ~full).
- sel_err  out  1  one-cycle pulse when an accepted word targeted a channel ≥ N_CH.

Behaviour:
- Target channel:
  - t = in_sel when MODE=0.
  - t = rr_ptr when MODE=1.
- Handshake:
  - in_ready = 1 when t ≥ N_CH.
  - Otherwise in_ready = ~out_valid[t] | out_ready[t]. This is combinational, so a word can be written into a slot in the same cycle that slot is drained.
- Input accept:
  - A word is accepted when in_valid & in_ready.
  - On the next edge: out_data[t] ← in_data and out_valid[t] ← 1.
  - Latency is 1 cycle from the input handshake to out_valid.
- Output drain:
  - A word leaves slot i when out_valid[i] & out_ready[i].
  - On that edge out_valid[i] ← 0, unless the same slot is reloaded in that cycle, in which case it stays 1 with the new data.
- Idle slots: out_data of an idle slot holds its last value and carries no meaning while out_valid=0.
- Other channels are unaffected by a stall on channel t. Only in_ready is affected.
- Round-robin pointer (MODE=1):
  - rr_ptr advances by 1 only on an accepted word.
  - It wraps from N_CH-1 to 0.
  - A stall holds rr_ptr on the stalled channel. There is no skipping.
- Out-of-range select (MODE=0 and in_sel ≥ N_CH; possible only when N_CH is not a power of 2):
  - The word is accepted and dropped.
  - sel_err is 1 for exactly the cycle following acceptance.
  - No slot changes.
- Reset (asynchronous, also when asserted mid-transfer):
  - out_valid = 0, out_data = 0, rr_ptr = 0, sel_err = 0.
  - in_ready becomes 1 combinationally, since all slots are empty.
  - Any word held in a slot is lost.
- Simultaneous events: accept into slot i, drain of slot j and reset can all coincide. Reset wins; otherwise the two operations are independent.

Optional Feature:
- Macro: DEMUX_NCH_CNT_EN.
- When defined:
  - Adds output port word_cnt (N_CH*16 bits).
  - Each 16-bit field counts the words accepted into that channel.
  - Counters wrap at 65535 → 0 and reset to 0.
  - Dropped (sel_err) words are not counted.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package demux_nch_pkg:
  - MODE_SEL=0 and MODE_RR=1 constants.
  - Default WIDTH and N_CH.
  - CNT_W=16.
- Sub-module demux_slot, instantiated N_CH times in a generate loop:
  - One-entry holding register.
  - Inputs: load, din, drain. Outputs: valid, dout.
  - Contains the load/drain precedence rule.
- The top level holds target decode, the in_ready mux, rr_ptr, sel_err and the optional counters.

Test Plan:
Benches use N_CH=4, WIDTH=10 unless stated otherwise.
1. MODE=0, all out_ready=1; send 0x155 with in_sel=2 → next cycle out_valid=4'b0100, slot 2 = 0x155; following cycle out_valid=0.
2. MODE=0, out_ready[1]=0; send 0x011 then 0x022, both to sel=1 → first accepted; in_ready=0 for the second. Raise out_ready[1] → 0x011 drains and 0x022 loads on the same edge, out_valid[1] stays 1.
3. MODE=1, all ready; send 0x001..0x006 → words land in slots 0,1,2,3,0,1 in order; rr_ptr ends at 2.
4. MODE=1, out_ready[2]=0 with slot 2 full → in_ready stays 0 when rr_ptr=2; channels 0,1,3 keep draining; rr_ptr does not advance until slot 2 drains.
5. N_CH=3, MODE=0; send in_sel=3 with data 0x3FF → in_ready=1, sel_err pulses for 1 cycle, out_valid stays 0; with DEMUX_NCH_CNT_EN defined, all counters remain 0.
6. Fill all 4 slots with out_ready=0, then assert reset between edges → out_valid=0 and out_data=0 immediately; after release, rr_ptr=0 and a new word to sel=0 lands with 1-cycle latency.
